// File: rtl/alu_pipelined.sv
// Registered MIPS R-type ALU: combinational result/flag logic feeding a single
// output register stage, one clock of latency, new operation every cycle.
module alu_pipelined #(
    parameter int NB_DATA     = 8,
    parameter int NB_OPERADOR = 6
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_DATA-1:0]     i_dato_a,
    input  logic [NB_DATA-1:0]     i_dato_b,
    input  logic [NB_OPERADOR-1:0] i_operador,
    output logic [NB_DATA-1:0]     o_resultado,
    output logic                   o_valid,
    output logic                   o_zero,
    output logic                   o_overflow
);

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

    function automatic logic sub_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_r);
        return (sign_a != sign_b) && (sign_r != sign_a);
    endfunction

    // The full unsigned amount is honoured, so oversize shifts saturate to the fill value.
    function automatic logic [NB_DATA-1:0] shift_right(input logic [NB_DATA-1:0] val,
                                                       input logic [NB_DATA-1:0] amt,
                                                       input logic arith);
        logic fill;
        fill = arith & val[NB_DATA-1];
        if (amt >= SHIFT_LIMIT)
            return {NB_DATA{fill}};
        else if (arith)
            return $unsigned($signed(val) >>> amt);
        else
            return val >> amt;
    endfunction

    // Stage p0: combinational operation decode and result
    logic signed [NB_DATA-1:0] a_p0;
    logic signed [NB_DATA-1:0] b_p0;
    logic signed [NB_DATA-1:0] sum_p0;
    logic signed [NB_DATA-1:0] diff_p0;
    logic        [5:0]         op_p0;
    logic        [NB_DATA-1:0] res_p0;
    logic                      ovf_p0;

    assign a_p0    = i_dato_a;
    assign b_p0    = i_dato_b;
    assign op_p0   = i_operador[5:0];
    assign sum_p0  = a_p0 + b_p0;
    assign diff_p0 = a_p0 - b_p0;

    always_comb begin
        res_p0 = '0;
        ovf_p0 = 1'b0;
        case (op_p0)
            OP_ADD: begin
                res_p0 = sum_p0;
                ovf_p0 = add_ovf(a_p0[NB_DATA-1], b_p0[NB_DATA-1], sum_p0[NB_DATA-1]);
            end
            OP_SUB: begin
                res_p0 = diff_p0;
                ovf_p0 = sub_ovf(a_p0[NB_DATA-1], b_p0[NB_DATA-1], diff_p0[NB_DATA-1]);
            end
            OP_AND: res_p0 = i_dato_a & i_dato_b;
            OP_OR:  res_p0 = i_dato_a | i_dato_b;
            OP_XOR: res_p0 = i_dato_a ^ i_dato_b;
            OP_NOR: res_p0 = ~(i_dato_a | i_dato_b);
            OP_SRA: res_p0 = shift_right(i_dato_a, i_dato_b, 1'b1);
            OP_SRL: res_p0 = shift_right(i_dato_a, i_dato_b, 1'b0);
            default: begin
                res_p0 = '0;
                ovf_p0 = 1'b0;
            end
        endcase
    end

    // Stage p1: output register; data holds when no valid operation arrives
    logic [NB_DATA-1:0] res_p1;
    logic               zero_p1;
    logic               ovf_p1;
    logic               vld_p1;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            res_p1  <= '0;
            zero_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= i_valid;
            if (i_valid) begin
                res_p1  <= res_p0;
                zero_p1 <= (res_p0 == '0);
                ovf_p1  <= ovf_p0;
            end
        end
    end

    assign o_resultado = res_p1;
    assign o_zero      = zero_p1;
    assign o_overflow  = ovf_p1;
    assign o_valid     = vld_p1;

endmodule

// File: tb/tb_alu_pipelined.sv
// Directed-vector bench for alu_pipelined at NB_DATA=5: reset behaviour,
// every function code, shift boundaries, hold on idle and back-to-back issue.
module tb_alu_pipelined;

    localparam int NB_DATA     = 5;
    localparam int NB_OPERADOR = 6;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] UND = 6'b111111;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   valid;
    logic [NB_DATA-1:0]     dato_a;
    logic [NB_DATA-1:0]     dato_b;
    logic [NB_OPERADOR-1:0] operador;
    logic [NB_DATA-1:0]     resultado;
    logic                   out_valid;
    logic                   zero;
    logic                   overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [5:0]   op;
        logic [4:0]   a;
        logic [4:0]   b;
        logic [4:0]   res;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    alu_pipelined #(
        .NB_DATA    (NB_DATA),
        .NB_OPERADOR(NB_OPERADOR)
    ) dut (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_valid    (valid),
        .i_dato_a   (dato_a),
        .i_dato_b   (dato_b),
        .i_operador (operador),
        .o_resultado(resultado),
        .o_valid    (out_valid),
        .o_zero     (zero),
        .o_overflow (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act[4:0], exp[4:0]);
        end
    endtask

    task automatic check_out(input string name, input logic [4:0] r, input logic z,
                             input logic o, input logic v);
        check({name, " result"},   {27'd0, resultado}, {27'd0, r});
        check({name, " zero"},     {31'd0, zero},      {31'd0, z});
        check({name, " overflow"}, {31'd0, overflow},  {31'd0, o});
        check({name, " valid"},    {31'd0, out_valid}, {31'd0, v});
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic [5:0] o, input logic [4:0] x, input logic [4:0] y,
                         input logic v);
        @(negedge clock);
        operador = o;
        dato_a   = x;
        dato_b   = y;
        valid    = v;
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input string n, input logic [5:0] o, input logic [4:0] x,
                           input logic [4:0] y, input logic [4:0] r, input logic z,
                           input logic ov);
        vec_t v;
        v.name = n; v.op = o; v.a = x; v.b = y; v.res = r; v.zero = z; v.ovf = ov;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec("add_basic", ADD, 5'b00101, 5'b01010, 5'b01111, 1'b0, 1'b0);
        add_vec("sub_neg",   SUB, 5'b00110, 5'b00111, 5'b11111, 1'b0, 1'b0);
        add_vec("add_ovf",   ADD, 5'b01111, 5'b00001, 5'b10000, 1'b0, 1'b1);
        add_vec("undef",     UND, 5'b01111, 5'b00001, 5'b00000, 1'b1, 1'b0);
        add_vec("sub_ovf",   SUB, 5'b10000, 5'b00001, 5'b01111, 1'b0, 1'b1);
        add_vec("add_zero",  ADD, 5'b00011, 5'b11101, 5'b00000, 1'b1, 1'b0);
        add_vec("and",       AND, 5'b10101, 5'b00111, 5'b00101, 1'b0, 1'b0);
        add_vec("or",        OR,  5'b11001, 5'b01011, 5'b11011, 1'b0, 1'b0);
        add_vec("xor",       XOR, 5'b11111, 5'b01101, 5'b10010, 1'b0, 1'b0);
        add_vec("nor",       NOR, 5'b00110, 5'b10001, 5'b01000, 1'b0, 1'b0);
        add_vec("sra3",      SRA, 5'b10110, 5'd3,     5'b11110, 1'b0, 1'b0);
        add_vec("srl3",      SRL, 5'b11010, 5'd3,     5'b00011, 1'b0, 1'b0);
        add_vec("sra7",      SRA, 5'b10110, 5'd7,     5'b11111, 1'b0, 1'b0);
        add_vec("srl5",      SRL, 5'b11010, 5'd5,     5'b00000, 1'b1, 1'b0);
        add_vec("srl0",      SRL, 5'b01101, 5'd0,     5'b01101, 1'b0, 1'b0);
        add_vec("sra_pos9",  SRA, 5'b01110, 5'd9,     5'b00000, 1'b1, 1'b0);

        // Reset held while operands stream in: nothing may be captured.
        reset    = 1'b0;
        valid    = 1'b1;
        operador = ADD;
        dato_a   = 5'b00101;
        dato_b   = 5'b01010;
        repeat (2) @(posedge clock);
        #1;
        check_out("reset_held", 5'b00000, 1'b0, 1'b0, 1'b0);

        @(negedge clock);
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clock);
        #1;
        check_out("release_idle", 5'b00000, 1'b0, 1'b0, 1'b0);

        drive(ADD, 5'b00001, 5'b00001, 1'b1);
        check_out("first_after_rst", 5'b00010, 1'b0, 1'b0, 1'b1);
        drive(ADD, 5'b01111, 5'b00001, 1'b1);
        check_out("pre_reset_ovf", 5'b10000, 1'b0, 1'b1, 1'b1);

        // Asynchronous assertion in the middle of the high phase.
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", 5'b00000, 1'b0, 1'b0, 1'b0);
        drive(SUB, 5'b00110, 5'b00111, 1'b1);
        check_out("inflight_drop", 5'b00000, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clock);
        #1;
        check_out("release2_idle", 5'b00000, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            check_out(vecs[i].name, vecs[i].res, vecs[i].zero, vecs[i].ovf, 1'b1);
        end

        // Idle cycles with moving inputs must leave the registered result alone.
        drive(ADD, 5'b01111, 5'b00001, 1'b1);
        check_out("hold_load", 5'b10000, 1'b0, 1'b1, 1'b1);
        drive(SUB, 5'b00011, 5'b00011, 1'b0);
        check_out("hold1", 5'b10000, 1'b0, 1'b1, 1'b0);
        drive(AND, 5'b10101, 5'b00111, 1'b0);
        check_out("hold2", 5'b10000, 1'b0, 1'b1, 1'b0);

        drive(ADD, 5'b00001, 5'b00010, 1'b1);
        check_out("b2b_add", 5'b00011, 1'b0, 1'b0, 1'b1);
        drive(SUB, 5'b00100, 5'b00110, 1'b1);
        check_out("b2b_sub", 5'b11110, 1'b0, 1'b0, 1'b1);
        drive(SUB, 5'b00100, 5'b00110, 1'b0);
        check_out("b2b_end", 5'b11110, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipelined.md
Name: alu_pipelined

Overview:
- Registered integer ALU for the datapath. Implements the MIPS R-type function codes ADD, SUB, AND, OR, XOR, NOR, SRA and SRL on two NB_DATA-bit operands.
- Operands and function code are sampled combinationally. The result and status flags are registered, giving one clock of latency.
- Sits between the operand/operation select logic and the writeback/display stage.

Parameters:
- NB_DATA, 8, operand and result width in bits; must be >= 2.
- NB_OPERADOR, 6, function-code width; codes below use the low 6 bits.

Ports:
- i_clock  in  1  rising-edge clock.
- i_reset  in  1  asynchronous reset, active-low.
- i_valid  in  1  operands and operation are valid this cycle.
- i_dato_a  in  NB_DATA  operand A; signed two's complement for ADD/SUB/SRA; the value shifted for SRA/SRL.
- i_dato_b  in  NB_DATA  operand B; signed for ADD/SUB; unsigned shift amount for SRA/SRL.
- i_operador  in  NB_OPERADOR  function code.
- o_resultado  out  NB_DATA  registered result.
- o_valid  out  1  o_resultado and flags are valid.
- o_zero  out  1  registered result is all zeros.
- o_overflow  out  1  signed overflow on ADD/SUB.

Behaviour:
- Reset:
  - i_reset low forces o_resultado=0, o_valid=0, o_zero=0 and o_overflow=0 immediately, independent of i_clock.
  - Release is sampled on the next rising edge.
  - Reset asserted mid-operation discards the in-flight result.
- Update rule: at each rising edge with i_reset high:
  - o_valid <= i_valid.
  - If i_valid=1, o_resultado, o_zero and o_overflow load from the combinational result of the current inputs.
  - If i_valid=0, they hold their previous values.
- Latency: exactly 1 cycle, with back-to-back operation every cycle. There is no stall input.
- Function codes (i_operador[5:0]):
  - 100000 ADD: A+B, truncated to NB_DATA.
  - 100010 SUB: A-B, truncated to NB_DATA.
  - 100100 AND: A&B.
  - 100101 OR: A|B.
  - 100110 XOR: A^B.
  - 100111 NOR: ~(A|B).
  - 000011 SRA: arithmetic shift of A right by B, sign-filled.
  - 000010 SRL: logical shift of A right by B, zero-filled.
  - Any other code: result 0, o_overflow 0, o_zero 1.
- Shift amount:
  - B is the full unsigned value.
  - B >= NB_DATA gives SRL=0, and SRA=all-ones if A is negative, else 0.
  - B=0 passes A unchanged.
- o_overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
  - All other operations: 0.
- o_zero = (result == 0) for every operation, including wrapped ADD/SUB results.
- There is no carry output; the carry-out is discarded.
- All result logic is purely combinational ahead of a single register stage. There are no other internal states.

Test Plan:
- Use NB_DATA=5 and NB_OPERADOR=6. Drive i_valid=1 and check each result one edge later.
- Reset: hold i_reset=0 while driving operands, then assert reset mid-stream.
  - Required: all outputs are 0 immediately and no result appears.
  - After release: the first result appears one edge after the first i_valid.
- Arithmetic:
  - ADD 00101+01010 -> 01111, ovf 0.
  - SUB 00110-00111 -> 11111, ovf 0.
  - ADD 01111+00001 -> 10000, ovf 1.
  - SUB 10000-00001 -> 01111, ovf 1.
  - ADD 00011+11101 -> 00000, zero 1.
- Logic:
  - AND 10101,00111 -> 00101.
  - OR 11001,01011 -> 11011.
  - XOR 11111,01101 -> 10010.
  - NOR 00110,10001 -> 01000.
- Shifts:
  - SRA 10110 by 3 -> 11110.
  - SRL 11010 by 3 -> 00011.
  - SRA 10110 by 7 -> 11111.
  - SRL 11010 by 5 -> 00000.
  - SRL 01101 by 0 -> 01101.
- Control:
  - Undefined code 111111 -> result 00000, zero 1.
  - i_valid=0 for 2 cycles with changing inputs: outputs hold, o_valid=0.
  - Back-to-back ADD then SUB on consecutive cycles: results appear on consecutive cycles.
